// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types for the instruction-fetch stage
package fetch_pkg;

  typedef logic [31:0] Word;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    Word pc;
    Word instr;
    Word pred_pc;
  } fetch_packet_t;

  localparam Word RESET_PC_DEFAULT = 32'hbfc0_0000;

  function automatic Word align_word(input Word addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - decode-side packet FIFO; flush wins over a same-cycle push
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_packet_t          push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_packet_t          head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_packet_t    mem_q [DEPTH];
  fetch_packet_t    mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign do_pop = pop && (count_q != '0);
  assign head   = mem_q[rd_q];
  assign count  = count_q;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC owner: one outstanding imem read, predictor handshake, decode FIFO
module fetch_unit
  import fetch_pkg::*;
#(
  parameter Word RESET_PC = RESET_PC_DEFAULT,
  parameter int  DEPTH    = 2
) (
  input  logic clk,
  input  logic reset,
  output logic imem_req,
  output Word  imem_addr,
  input  logic imem_gnt,
  input  logic imem_rvalid,
  input  Word  imem_rdata,
  output Word  cur_pc,
  output Word  cur_instr,
  output logic pred_en,
  input  Word  pred_pc,
  input  logic redirect,
  input  Word  redirect_pc,
  output logic out_valid,
  input  logic out_ready,
  output Word  out_pc,
  output Word  out_instr,
  output Word  out_pred_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_state_t     state_q, state_d;
  Word              pc_q, pc_d;
  logic             push, pop, flush;
  fetch_packet_t    push_data, head;
  logic [CNT_W-1:0] count;

  assign imem_addr = pc_q;
  assign cur_pc    = pc_q;
  assign cur_instr = imem_rdata;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push_data = '{pc: pc_q, instr: imem_rdata, pred_pc: pred_pc};

  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign out_pred_pc = head.pred_pc;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_req = 1'b0;
    pred_en  = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    if (!reset) begin
      if (redirect) begin
        flush = 1'b1;
        pc_d  = align_word(redirect_pc);
        // An in-flight read must still be swallowed before a new request.
        if (state_q != REQ) begin
          state_d = imem_rvalid ? REQ : DROP;
        end
      end else begin
        case (state_q)
          REQ: begin
            imem_req = (count < FULL);
            if (imem_req && imem_gnt) begin
              state_d = WAIT;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              pred_en = 1'b1;
              push    = 1'b1;
              pc_d    = align_word(pred_pc);
              state_d = REQ;
            end
          end
          DROP: begin
            if (imem_rvalid) begin
              state_d = REQ;
            end
          end
          default: state_d = REQ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .count    (count)
  );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the frontend branch predictor. It owns the architectural fetch PC and issues one instruction-memory read at a time. Each returned word is presented to the predictor as `cur_pc`/`cur_instr`, and the predictor's `pred_pc` is taken as the next fetch address. Fetched packets go to decode through a small FIFO; backend redirects (mispredict recovery) flush the FIFO and any in-flight read.

## Interface
- `RESET_PC`, default 32'hbfc0_0000: fetch address after reset.
- `DEPTH`, default 2: decode FIFO entries, power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  read request valid.
- `imem_addr`  out  32  read address, equal to PC, bits [1:0] = 0.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  read data valid. The accepted request's data returns ≥1 cycle after grant.
- `imem_rdata`  in  32  read data.
- `cur_pc`, `cur_instr`  out  32 each  to predictor; valid when `pred_en`=1.
- `pred_en`  out  1  drives predictor `en`; high only on a cycle that accepts a live response.
- `pred_pc`  in  32  predictor's next-PC for `cur_pc`/`cur_instr`, same cycle.
- `redirect`  in  1  backend mispredict/exception flush.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] are forced to 0.
- `out_valid`  out  1  decode packet available.
- `out_ready`  in  1  decode accepts the head packet.
- `out_pc`, `out_instr`, `out_pred_pc`  out  32 each  head packet.

## Operation
- State machine:
  - REQ: `imem_req` = !redirect && count<DEPTH. Grant → WAIT.
  - WAIT: a live response is accepted on `imem_rvalid`.
  - DROP: the next `imem_rvalid` is discarded.
- Live response in WAIT:
  - `pred_en`=1.
  - Push {pc, rdata, pred_pc} into FIFO.
  - PC ← {pred_pc[31:2],2'b0}.
  - → REQ.
- Credit rule: a request is issued only when the FIFO has space, and there is at most one outstanding read, so a push never finds the FIFO full. No overflow path exists.
- `cur_pc` = PC register at all times. `cur_instr` = `imem_rdata`.
- `pred_en`=0 in every other case: REQ, WAIT without rvalid, DROP, or a redirect cycle. The predictor's history therefore advances exactly once per delivered instruction.
- Redirect (highest priority):
  - FIFO flushed: count ← 0, `out_valid` falls next cycle.
  - PC ← redirect_pc.
  - `imem_req` suppressed that cycle.
  - Next state:
    - in REQ: REQ.
    - in WAIT with rvalid same cycle: response discarded, → REQ.
    - in WAIT without rvalid: DROP.
    - in DROP with rvalid: REQ.
    - in DROP without rvalid: stay in DROP.
- Pop when `out_valid && out_ready`.
  - Simultaneous push and pop keeps the count.
  - A pop at count 0 is impossible (`out_valid`=0).
- FIFO pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits wide.

## Timing
- Reset values:
  - state=REQ, PC=RESET_PC, count=0, pointers=0.
  - `out_valid`=0, `pred_en`=0.
  - `imem_req`=0 while `reset`=1 and 1 from the first cycle after.
- Reset mid-WAIT: the outstanding response is not tracked. The memory system is reset on the same signal.
- Grant to earliest next request: 2 cycles (grant, rvalid, then REQ).
- Best-case throughput: 1 instruction per 2 cycles with 1-cycle memory.
- rvalid to `out_valid`: 1 cycle (FIFO registered).
- Redirect to new-PC `imem_req`: 1 cycle, or after the stale rvalid if the redirect arrives in WAIT.
- Outputs `out_*` are registered from FIFO storage. `imem_req` and `pred_en` are combinational from state, count, `redirect` and `imem_rvalid`.

## Structure
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t` {REQ, WAIT, DROP}.
  - packed struct `fetch_packet_t` {pc, instr, pred_pc}.
  - `Word` typedef.
- Sub-module `fetch_queue` #(DEPTH): synchronous FIFO of `fetch_packet_t` with push, pop, flush, count. Flush overrides push in the same cycle.
- Top holds PC, state machine and predictor handshake, roughly 150 lines plus 100 for the queue.

## Test plan
- Reset, 1-cycle memory, `out_ready`=1, predictor returns pc+4:
  - First `imem_addr`=0xbfc00000, then 0xbfc00004.
  - Packets arrive 2 cycles apart.
  - `pred_en` high exactly on rvalid cycles.
- `out_ready`=0: after 2 packets count=2, `imem_req` stays 0, and no third grant occurs. Raising `out_ready` pops 0xbfc00000 first.
- Predictor returns 0x80001000 for pc 0xbfc00008: the next `imem_addr`=0x80001000 and `out_pred_pc`=0x80001000 for that packet.
- Redirect to 0x80002002 in WAIT two cycles before rvalid:
  - FIFO empties and the stale word is dropped with `pred_en`=0.
  - The next request address is 0x80002000.
- Redirect coincident with rvalid in WAIT: the word is discarded, there is no push, and `imem_req` for the redirect PC is raised the next cycle.
- Simultaneous push and pop at count=1 keeps count=1. Random grant/rvalid delays (0–5 cycles) with a scoreboard check in-order, gap-free PCs.
